// File: rtl/count_display_scan.sv
// Display stage for a mod-N counter: counts wrap events (saturating) and
// scans four active-low seven-segment digits showing count, mode and events.
module count_display_scan #(
  parameter int N           = 7,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic [2:0] ctrl,
  input  logic       clr_events,
  output logic [7:0] wrap_count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  // Compared in 5 bits so that N=16 still yields a top value of 15.
  localparam logic [4:0]     CNT_TOP  = 5'(N - 1);

  logic [3:0]       r_count_d;
  logic             r_prev_valid;
  logic [7:0]       r_wrap_count;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_wrap;
  logic [4:0]       w_sym;
  logic [6:0]       w_seg;

  assign w_wrap = r_prev_valid &&
                  ((({1'b0, r_count_d} == CNT_TOP) && (count == 4'd0)) ||
                   ((r_count_d == 4'd0) && ({1'b0, count} == CNT_TOP)));

  // Symbol code: 0x00-0x0F hex digits, 0x10-0x14 mode glyphs U,d,b,L,H.
  always_comb begin
    w_sym = 5'h00;
    case (r_idx)
      2'd0: w_sym = {1'b0, count};
      2'd1: w_sym = {2'b10, (ctrl[2] ? 3'd4 : ctrl)};
      2'd2: w_sym = {1'b0, r_wrap_count[3:0]};
      2'd3: w_sym = {1'b0, r_wrap_count[7:4]};
      default: w_sym = 5'h00;
    endcase
  end

  always_comb begin
    w_seg = 7'b1111111;
    case (w_sym)
      5'h00: w_seg = 7'b1000000;
      5'h01: w_seg = 7'b1111001;
      5'h02: w_seg = 7'b0100100;
      5'h03: w_seg = 7'b0110000;
      5'h04: w_seg = 7'b0011001;
      5'h05: w_seg = 7'b0010010;
      5'h06: w_seg = 7'b0000010;
      5'h07: w_seg = 7'b1111000;
      5'h08: w_seg = 7'b0000000;
      5'h09: w_seg = 7'b0010000;
      5'h0A: w_seg = 7'b0001000;
      5'h0B: w_seg = 7'b0000011;
      5'h0C: w_seg = 7'b1000110;
      5'h0D: w_seg = 7'b0100001;
      5'h0E: w_seg = 7'b0000110;
      5'h0F: w_seg = 7'b0001110;
      5'h10: w_seg = 7'b1000001;
      5'h11: w_seg = 7'b0100001;
      5'h12: w_seg = 7'b0000011;
      5'h13: w_seg = 7'b1000111;
      5'h14: w_seg = 7'b0001001;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count_d    <= 4'd0;
      r_prev_valid <= 1'b0;
      r_wrap_count <= 8'd0;
      r_pre        <= '0;
      r_idx        <= 2'd0;
      r_an         <= 4'b1111;
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
    end else begin
      r_count_d    <= count;
      r_prev_valid <= 1'b1;
      if (clr_events) begin
        r_wrap_count <= 8'd0;
      end else if (w_wrap && (r_wrap_count != 8'hFF)) begin
        r_wrap_count <= r_wrap_count + 8'd1;
      end
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= !((r_idx == 2'd3) && (r_wrap_count == 8'hFF));
    end
  end

  assign wrap_count = r_wrap_count;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan with N=7 and REFRESH_DIV=4.
module tb_count_display_scan;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic [2:0] ctrl;
  logic       clr_events;
  logic [7:0] wrap_count;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;  // edges since reset release; 0 while in reset

  count_display_scan #(.N(7), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .ctrl       (ctrl),
    .clr_events (clr_events),
    .wrap_count (wrap_count),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1:0] dig_of(input int c);
    return 2'(((c - 1) / 4) % 4);
  endfunction

  function automatic logic [3:0] exp_an(input int c);
    if (c == 0) return 4'b1111;
    return 4'(~(4'b0001 << dig_of(c)));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock edge, then check the digit enable against the scan model.
  task automatic step();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc++;
    #1;
    chk("an", {4'b0, an}, {4'b0, exp_an(cyc)});
  endtask

  initial begin
    logic [2:0] sweep_ctrl [4];
    logic [6:0] sweep_seg  [4];
    logic       found;
    logic [6:0] exp_dig_seg [4];
    sweep_ctrl = '{3'd1, 3'd2, 3'd3, 3'd5};
    sweep_seg  = '{7'b0100001, 7'b0000011, 7'b1000111, 7'b0001001};
    exp_dig_seg = '{7'b0000010, 7'b1000001, 7'b1000000, 7'b1000000};

    rst = 1'b1; count = 4'd6; ctrl = 3'd0; clr_events = 1'b0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_seg", {1'b0, seg}, 8'h7F);
      chk("rst_dp", {7'b0, dp}, 8'h01);
      chk("rst_wrap", wrap_count, 8'h00);
    end

    // Release; count=6 is N-1 against count_d=0 but prev_valid blocks it
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("scan_seg", {1'b0, seg}, {1'b0, exp_dig_seg[dig_of(cyc)]});
    end
    chk("no_event_first", wrap_count, 8'h00);

    // Wrap counting: 5,6,0,1 then 1,0,6 then 3,0
    count = 4'd5; step(); chk("w5", wrap_count, 8'd0);
    count = 4'd6; step(); chk("w6", wrap_count, 8'd0);
    count = 4'd0; step(); chk("w0_up", wrap_count, 8'd1);
    count = 4'd1; step(); chk("w1", wrap_count, 8'd1);
    count = 4'd1; step(); chk("w1b", wrap_count, 8'd1);
    count = 4'd0; step(); chk("w0", wrap_count, 8'd1);
    count = 4'd6; step(); chk("w6_down", wrap_count, 8'd2);
    count = 4'd3; step(); chk("w3", wrap_count, 8'd2);
    count = 4'd0; step(); chk("jump_3_0", wrap_count, 8'd2);

    // Clear has priority over a simultaneous wrap
    count = 4'd6; clr_events = 1'b1; step(); chk("clr_prio", wrap_count, 8'd0);
    clr_events = 1'b0;
    count = 4'd0; step(); chk("after_clr", wrap_count, 8'd1);

    // 260 back-to-back wraps saturate at 255
    for (int i = 0; i < 260; i++) begin
      count = (i % 2 == 0) ? 4'd6 : 4'd0;
      step();
    end
    chk("saturate", wrap_count, 8'hFF);

    // One full frame at saturation: dp only on digit 3, digits 2/3 show F
    for (int i = 0; i < 16; i++) begin
      step();
      chk("sat_hold", wrap_count, 8'hFF);
      chk("sat_dp", {7'b0, dp}, (dig_of(cyc) == 2'd3) ? 8'h00 : 8'h01);
      if (dig_of(cyc) >= 2'd2) chk("sat_segF", {1'b0, seg}, 8'h0E);
    end

    clr_events = 1'b1; step(); chk("clr_sat", wrap_count, 8'd0);
    clr_events = 1'b0;
    count = 4'd6; step(); chk("pre_rst_wrap", wrap_count, 8'd1);

    // Reset while digit 2 is enabled
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (cyc > 0 && dig_of(cyc) == 2'd2) found = 1'b1;
    end
    chk("find_digit2", {7'b0, found}, 8'h01);
    rst = 1'b1; step();
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_dp", {7'b0, dp}, 8'h01);
    chk("mid_rst_wrap", wrap_count, 8'h00);
    rst = 1'b0; step();

    // Mode glyph sweep on digit 1
    for (int k = 0; k < 4; k++) begin
      ctrl = sweep_ctrl[k];
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        step();
        if (dig_of(cyc) == 2'd1) found = 1'b1;
      end
      chk("find_digit1", {7'b0, found}, 8'h01);
      chk("glyph", {1'b0, seg}, {1'b0, sweep_seg[k]});
    end
    chk("no_event_post_rst", wrap_count, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/count_display_scan.md
# count_display_scan

Downstream display stage for the mod-N up/down counter. Samples the counter's 4-bit `count` and 3-bit `ctrl` every cycle. Counts wrap-around events in a saturating 8-bit register. Time-multiplexes four active-low seven-segment digits: count value, mode glyph, and the event count in hex. It sits between the counter and the board's common-anode display pins.

## Interface
- `N`, 7: modulus of the upstream counter (2..16); defines wrap detection.
- `REFRESH_DIV`, 100000: clock cycles each digit stays enabled (>=2); set to 4 in simulation.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `count` in 4: upstream counter value, assumed in 0..N-1.
- `ctrl` in 3: upstream mode (0 up, 1 down, 2 up/down, 3 load, 4-7 hold).
- `clr_events` in 1: synchronous clear of `wrap_count`.
- `wrap_count` out 8: number of wrap events seen, saturating at 255.
- `an` out 4: digit enables, active low, one-hot-low when running.
- `seg` out 7: segments active low, `seg[0]`=a … `seg[6]`=g.
- `dp` out 1: decimal point, active low.

## Operation
- **Sampling:** `count_d` holds the previous cycle's `count`. `prev_valid` is cleared by reset and set on the first non-reset edge. No event is detected while `prev_valid`=0.
- **Wrap event:** `prev_valid` && ((`count_d`==N-1 && `count`==0) || (`count_d`==0 && `count`==N-1)). Detection uses value transitions only; `ctrl` is ignored, so a load producing such a transition also counts.
- **Event counter:**
  - `clr_events` sets it to 0 and has priority over an increment in the same cycle.
  - Otherwise a wrap event increments it.
  - It holds at 255 (no wrap-around to 0).
- **Prescaler:** `pre` counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it returns to 0 and the digit index `idx` advances 0→1→2→3→0.
- **Digit content per `idx`:**
  - 0: hex of `count`.
  - 1: mode glyph.
  - 2: hex of `wrap_count[3:0]`.
  - 3: hex of `wrap_count[7:4]`.
- **Mode glyphs** (`seg` as bits 6..0):
  - ctrl 0 'U' = 1000001
  - ctrl 1 'd' = 0100001
  - ctrl 2 'b' = 0000011
  - ctrl 3 'L' = 1000111
  - ctrl 4-7 'H' = 0001001
- **Hex glyphs:** standard. Examples: 0=1000000, 1=1111001, 2=0100100, 6=0000010, F=0001110.
- **`an`:** bit `idx` low, others high.
- **`dp`:** low only when `idx`==3 and `wrap_count`==255; otherwise high.
- **Encoder:** a single shared hex/glyph encoder feeds registered `an`/`seg`/`dp`.

## Timing
- **Reset values:**
  - `an`=1111 (all dark), `seg`=1111111, `dp`=1, `wrap_count`=0.
  - Internal: `pre`=0, `idx`=0, `prev_valid`=0, `count_d`=0.
- **First digit:** at the first non-reset edge, `an` becomes 1110.
- **Display latency:** `an`/`seg`/`dp` are registered from the current `idx` and the current `count`/`ctrl`/`wrap_count`, so they lag by 1 cycle. A change on `count` appears on `seg` one edge later while digit 0 is enabled.
- **Wrap latency:** if `count` wraps at edge k, the event is combinationally visible during cycle k and `wrap_count` increments at edge k+1. The display reflects it at edge k+2, when digit 2/3 is active.
- **Digit period:** each digit is enabled for exactly REFRESH_DIV cycles. Full frame = 4·REFRESH_DIV cycles.
- **Reset mid-scan:** all state returns to reset values at that edge; the scan restarts at digit 0.
- **Back-to-back events:** wraps on consecutive cycles (e.g. N=2) each increment `wrap_count`.
- **Width rule:** the comparison `count_d`==N-1 is done in 5 bits so N=16 yields 15 correctly.

## Test plan
- **Reset release:** assert `rst` for 3 cycles, release -> during reset `an`=1111, `seg`=1111111, `wrap_count`=0; one edge after release `an`=1110.
- **Scan order (REFRESH_DIV=4):** hold `count`=6, `ctrl`=0 -> `an` 1110 for 4 cycles with `seg`=0000010, then 1101 for 4 cycles with `seg`=1000001, then 1011, 0111, then 1110 again.
- **Wrap counting (N=7):**
  - Drive `count` 5,6,0,1 -> `wrap_count` goes 0→1 one edge after 0 appears.
  - Then drive 1,0,6 -> `wrap_count`=2.
  - A jump 3→0 does not increment.
- **Saturation and dp:** generate 260 wraps -> `wrap_count`=255; `dp`=0 only while `an`=0111, with digits 2/3 both showing F = 0001110.
- **Clear priority:** assert `clr_events` in the same cycle as a wrap event -> `wrap_count`=0 next edge, not 1.
- **Reset mid-scan and mode glyphs:**
  - Assert `rst` while `an`=1011 -> `an`=1111 next edge, then restart at 1110.
  - Sweep `ctrl` 1,2,3,5 -> digit 1 shows 0100001, 0000011, 1000111, 0001001.
